// File: rtl/approx_err_pkg.sv
// ---------------------------------------------------------------------------
// approx_err_pkg : shared FSM state type and saturating-add helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package approx_err_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Widths up to 64 bits; the result clamps at 2^width-1 instead of wrapping.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (65'd1 << width) - 65'd1;
    sat_add = (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/err_distance.sv
// ---------------------------------------------------------------------------
// err_distance : exact modulo-2^N sum and error distance to the approximate sum
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module err_distance #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] approx_sum,
  output logic [N-1:0] ed,
  output logic         mismatch
);

  logic [N-1:0] w_exact;

  assign w_exact  = a + b;
  assign mismatch = (w_exact != approx_sum);

  always_comb begin
    ed = '0;
    if (w_exact >= approx_sum) ed = w_exact - approx_sum;
    else                       ed = approx_sum - w_exact;
  end

endmodule

`default_nettype wire

// File: rtl/approx_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_err_monitor : streaming accuracy statistics for an approximate adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module approx_err_monitor
  import approx_err_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  input  logic             clear_stats,
  input  logic             dump_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N-1:0]     max_ed
);

  state_t       r_state;
  logic         r_s1_valid;
  logic [N-1:0] r_s1_a;
  logic [N-1:0] r_s1_b;
  logic [N-1:0] r_s1_approx;
  logic         r_s2_valid;
  logic [N-1:0] r_s2_ed;
  logic         r_s2_err;
  logic [N-1:0] w_ed;
  logic         w_mismatch;
  logic         w_accept;
  logic         w_clr;
  logic         w_pipe_empty;

  assign w_accept     = in_valid && in_ready;
  assign w_clr        = clear_stats && (r_state == ST_RUN);
  assign w_pipe_empty = !w_accept && !r_s1_valid && !r_s2_valid;

  // S1: registered sample; distance computed from the registered operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_approx <= '0;
    end else begin
      r_s1_valid <= w_accept && !w_clr;
      if (w_accept) begin
        r_s1_a      <= a;
        r_s1_b      <= b;
        r_s1_approx <= approx_sum;
      end
    end
  end

  err_distance #(.N(N)) u_err_distance (
    .a          (r_s1_a),
    .b          (r_s1_b),
    .approx_sum (r_s1_approx),
    .ed         (w_ed),
    .mismatch   (w_mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_ed    <= '0;
      r_s2_err   <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid && !w_clr;
      r_s2_ed    <= w_ed;
      r_s2_err   <= w_mismatch;
    end
  end

  // Accumulators double as the report fields; nothing moves them in REPORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      max_ed     <= '0;
    end else if (w_clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      max_ed     <= '0;
    end else if (r_s2_valid) begin
      sample_cnt <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W));
      err_cnt    <= CNT_W'(sat_add(64'(err_cnt), 64'(r_s2_err), CNT_W));
      ed_sum     <= ACC_W'(sat_add(64'(ed_sum), 64'(r_s2_ed), ACC_W));
      if (r_s2_ed > max_ed) max_ed <= r_s2_ed;
    end
  end

  // An empty pipeline skips DRAIN; otherwise leave once S1 has drained,
  // since the final S2 update lands on the same edge as the REPORT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (dump_req && !w_clr) begin
            in_ready <= 1'b0;
            if (w_pipe_empty) begin
              r_state   <= ST_REPORT;
              out_valid <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!r_s1_valid) begin
            r_state   <= ST_REPORT;
            out_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            r_state   <= ST_RUN;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_approx_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_approx_err_monitor : directed + randomized checks against a statistics model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_approx_err_monitor;

  localparam int N     = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;
  localparam int SAT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic clear_stats = 1'b0;
  logic dump_req = 1'b0;
  logic out_ready = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] approx_sum = '0;

  logic in_ready, out_valid, s_in_ready, s_out_valid;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [ACC_W-1:0] ed_sum, s_ed_sum;
  logic [N-1:0]     max_ed, s_max_ed;
  logic [SAT_W-1:0] s_sample_cnt, s_err_cnt;

  always #5 clk = ~clk;

  approx_err_monitor #(.N(N), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum), .clear_stats(clear_stats),
    .dump_req(dump_req), .out_valid(out_valid), .out_ready(out_ready),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .ed_sum(ed_sum), .max_ed(max_ed)
  );

  approx_err_monitor #(.N(N), .CNT_W(SAT_W), .ACC_W(ACC_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .approx_sum(approx_sum), .clear_stats(clear_stats),
    .dump_req(dump_req), .out_valid(s_out_valid), .out_ready(out_ready),
    .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt), .ed_sum(s_ed_sum), .max_ed(s_max_ed)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference statistics: m_* for the wide instance, s_* for the 4-bit counters
  longint unsigned m_cnt, m_err, m_sum, m_max, s_cnt, s_err;

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; s_cnt = 0; s_err = 0;
  endtask

  task automatic model_add(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] ap);
    longint unsigned ex, ed;
    ex = (longint'(x) + longint'(y)) % (64'd1 << N);
    ed = (ex >= longint'(ap)) ? ex - longint'(ap) : longint'(ap) - ex;
    m_cnt++;
    m_sum += ed;
    if (ed > m_max) m_max = ed;
    if (s_cnt < 15) s_cnt++;
    if (ed != 0) begin
      m_err++;
      if (s_err < 15) s_err++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_sample_cnt"}, 64'(sample_cnt), m_cnt);
    chk({tag, "_err_cnt"},    64'(err_cnt),    m_err);
    chk({tag, "_ed_sum"},     64'(ed_sum),     m_sum);
    chk({tag, "_max_ed"},     64'(max_ed),     m_max);
    chk({tag, "_sat_cnt"},    64'(s_sample_cnt), s_cnt);
    chk({tag, "_sat_err"},    64'(s_err_cnt),    s_err);
  endtask

  // One RUN-state cycle; the model tracks what the stats must become.
  task automatic drive(input bit v, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [N-1:0] ap, input bit clr, input bit dmp);
    if (v) chk("in_ready_run", 64'(in_ready), 64'd1);
    in_valid = v; a = x; b = y; approx_sum = ap; clear_stats = clr; dump_req = dmp;
    step();
    if (clr) model_clear();
    else if (v) model_add(x, y, ap);
    in_valid = 1'b0; clear_stats = 1'b0; dump_req = 1'b0;
  endtask

  task automatic drive_rand(input bit v, input bit clr, input bit dmp);
    logic [N-1:0] x, y, ap;
    x  = N'($urandom);
    y  = N'($urandom);
    ap = ($urandom_range(0, 1) == 1) ? N'(x + y) : N'($urandom);
    drive(v, x, y, ap, clr, dmp);
  endtask

  task automatic dump(input string tag, input int exp_lat, input bit with_smp, input bit hold);
    int lat;
    if (with_smp) drive_rand(1'b1, 1'b0, 1'b1);
    else          drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      step();
      lat++;
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    if (exp_lat > 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_stats(tag);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        step();
        chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
        check_stats({tag, "_hold"});
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
    chk({tag, "_err_cnt"},    64'(err_cnt),    64'd0);
    chk({tag, "_ed_sum"},     64'(ed_sum),     64'd0);
    chk({tag, "_max_ed"},     64'(max_ed),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) step();
    check_reset_state("reset_hold");
    rst_n = 1'b1;
    step();
    check_reset_state("reset_release");

    // Exact additions
    repeat (3) drive(1'b1, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b0);
    dump("exact", 0, 1'b0, 1'b0);

    // Wrap-around and off-by-one errors
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 16'hFFFF, 16'h0001, 16'hFF00, 1'b0, 1'b0);
    drive(1'b1, 16'hAAAA, 16'h5555, 16'hFFFE, 1'b0, 1'b0);
    dump("err", 0, 1'b0, 1'b0);

    // Backpressure, then an empty-pipeline dump returning the same stats
    dump("bp", 1, 1'b0, 1'b1);
    dump("bp_again", 1, 1'b0, 1'b0);

    // Full pipeline: samples in the two cycles up to and including the dump
    drive_rand(1'b1, 1'b0, 1'b0);
    dump("full", 3, 1'b1, 1'b0);

    // Clear with a sample still in flight
    drive(1'b1, 16'hFFFF, 16'h0001, 16'hFF00, 1'b0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    dump("clr_inflight", 0, 1'b0, 1'b0);

    // Clear beats dump in the same cycle: no report follows
    drive_rand(1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("clr_dump_no_report", 64'(out_valid), 64'd0);
      chk("clr_dump_in_ready", 64'(in_ready), 64'd1);
      step();
    end

    // Sample accepted together with clear is discarded
    drive_rand(1'b1, 1'b0, 1'b0);
    drive(1'b1, 16'h0000, 16'h0000, 16'h0007, 1'b1, 1'b0);
    dump("clr_with_sample", 0, 1'b0, 1'b0);

    // Randomized bursts, each ending in a dump that carries a sample
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 25; i++)
        drive_rand($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1'b0);
      dump("rand", 3, 1'b1, 1'b0);
    end

    // Saturation of the 4-bit counters
    drive(1'b0, '0, '0, '0, 1'b1, 1'b0);
    repeat (17) drive(1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0);
    dump("sat", 0, 1'b0, 1'b0);
    chk("sat_cnt_allones", 64'(s_sample_cnt), 64'hF);
    chk("sat_err_allones", 64'(s_err_cnt), 64'hF);

    // Asynchronous reset mid-stream while DRAIN is in progress
    repeat (5) drive_rand(1'b1, 1'b0, 1'b0);
    drive_rand(1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_drain");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_drain_report_lost", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset while a report is being held
    repeat (4) drive_rand(1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 12 && !out_valid; i++) step();
    chk("rst_report_entered", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("rst_report");
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_reset_state("rst_report_release");
    dump("post_reset", 1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-metric accumulator that sits downstream of an approximate adder under test. It accepts (a, b, approx_sum) samples over a valid/ready handshake and computes the exact modulo-2^N sum. It accumulates sample count, error count, error-distance sum and maximum error distance, and returns a stats snapshot over a report handshake on request. This replaces printed `$monitor` output with on-chip accuracy figures for the adder family.

## Interface
- N, 16, operand and sum width; must match the adder under test
- CNT_W, 32, width of sample and error counters
- ACC_W, 48, width of error-distance accumulator

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- a  in  N  operand A
- b  in  N  operand B
- approx_sum  in  N  approximate adder output, carry-out dropped
- clear_stats  in  1  single-cycle pulse, zero all statistics
- dump_req  in  1  single-cycle pulse, request stats report
- out_valid  out  1  report fields valid
- out_ready  in  1  consumer takes report
- sample_cnt  out  CNT_W  samples accumulated
- err_cnt  out  CNT_W  samples with approx_sum != exact
- ed_sum  out  ACC_W  sum of error distances
- max_ed  out  N  largest error distance seen

## Operation
- exact = (a + b) mod 2^N. ED = |exact - approx_sum|, the unsigned magnitude of the difference of two N-bit values.
- Two-stage pipeline:
  - S1 registers the accepted sample and computes exact and ED.
  - S2 updates the accumulators from the S1 valid.
- FSM states:
  - RUN: in_ready=1.
  - DRAIN: in_ready=0; waits until S1 and S2 are empty, at most 2 cycles.
  - REPORT: in_ready=0, out_valid=1.
- RUN -> DRAIN on dump_req. DRAIN -> REPORT when the pipeline is empty. REPORT -> RUN on out_valid&&out_ready.
- Counters and accumulator saturate at all-ones; they never wrap. max_ed updates when ED > max_ed.
- Statistics persist across a dump. Only clear_stats or reset zeroes them.
- clear_stats acts in RUN only and is ignored in DRAIN/REPORT. It zeroes all statistics and invalidates S1/S2 on the next edge.
- dump_req is ignored outside RUN.

## Timing
- Reset (rst_n low, asynchronous):
  - state=RUN, pipeline empty, all stats 0, out_valid=0.
  - in_ready reads 1 once state=RUN.
- A sample is accepted on the edge where in_valid&&in_ready. It is reflected in the stats 2 edges later.
- dump_req together with an accepted sample in the same cycle: the sample is counted. in_ready drops the following cycle.
- clear_stats together with an accepted sample: the sample is discarded. clear_stats takes priority over dump_req in the same cycle, and the dump is dropped.
- In REPORT, all output fields are held stable while out_ready=0. in_ready returns to 1 the cycle after the report handshake.
- Minimum dump latency: out_valid rises 3 cycles after dump_req with a full pipeline, or 1 cycle with an empty one.
- rst_n asserted mid-REPORT or mid-DRAIN: immediate return to the reset state, and the report is lost.

## Structure
- Shared package `approx_err_pkg` holds the FSM state enum (RUN, DRAIN, REPORT) and a saturating-add helper function.
- One sub-module, `err_distance`, is natural: combinational exact-sum and ED computation, parameterised by N, instantiated in S1.
- Estimated size: ~200 lines of RTL.

## Test plan
- Reset: rst_n low mid-stream -> all stats 0, out_valid=0; in_ready=1 after release.
- Exact samples: three samples of a=16'h1234, b=16'h5678, approx=16'h68AC, then dump -> sample_cnt=3, err_cnt=0, ed_sum=0, max_ed=0.
- Error samples: (FFFF, 0001, FF00) and (AAAA, 5555, FFFE), then dump -> sample_cnt=2, err_cnt=2, ed_sum=16'hFF01, max_ed=16'hFF00.
- Backpressure: hold out_ready=0 for 5 cycles in REPORT -> fields stable, in_ready=0; raise out_ready -> in_ready=1 next cycle; a second dump returns the same stats.
- Clear with in-flight data: accept an error sample, pulse clear_stats the next cycle, then dump -> all fields 0. dump_req and clear_stats in the same cycle -> no report.
- Saturation: CNT_W=4, 17 error samples of ED=1 -> sample_cnt=4'hF, err_cnt=4'hF.
